// File: rtl/change_monitor.sv
// change_monitor: watches a data bus and logs every value change as a
// {timestamp, value} record into a small first-word-fall-through FIFO.
// A downstream logger drains the records over a valid/ready read port.
module change_monitor #(
  parameter int DATA_W = 4,
  parameter int TS_W   = 16,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [DATA_W-1:0]        data_in,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [DATA_W-1:0]        rd_data,
  output logic [TS_W-1:0]          rd_time,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     clear_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [TS_W-1:0]   ts;
    logic [DATA_W-1:0] d;
  } rec_t;

  // Free-running timestamp and change-detection state
  logic [TS_W-1:0]   ts;
  logic [DATA_W-1:0] prev;
  logic              primed;

  // FIFO storage and bookkeeping
  rec_t              mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  rec_t              head;

  // Per-cycle decisions
  logic              pop;
  logic              want;
  logic              full;
  logic              push;
  logic              drop;
  logic [CW-1:0]     count_next;
  logic [CW-1:0]     held;
  logic [AW-1:0]     rd_ptr_next;
  rec_t              new_rec;
  rec_t              head_next;

  assign rd_data = head.d;
  assign rd_time = head.ts;

  // Decide what happens at the coming edge: pop, push, drop, and the new head
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    head_next   = head;
    pop         = rd_valid && rd_ready;
    want        = en && (!primed || (data_in != prev));
    full        = (count == FULL);
    push        = want && (!full || pop);
    drop        = want && full && !pop;
    count_next  = count + CW'(push) - CW'(pop);
    held        = count - CW'(pop);
    rd_ptr_next = rd_ptr + AW'(pop);
    new_rec     = '{ts: ts, d: data_in};
    // If nothing older survives the pop, the record being written becomes the head.
    if (held == '0) head_next = new_rec;
    else            head_next = mem[rd_ptr_next];
  end

  // Timestamp counter and change-detection state (prev value, primed flag)
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // sees pre-edge values of its neighbours.
    if (!rst_n) begin
      ts     <= '0;
      prev   <= '0;
      primed <= 1'b0;
    end else begin
      ts     <= ts + TS_W'(1);
      primed <= en;
      if (en) prev <= data_in;
    end
  end

  // FIFO pointers, occupancy, registered head record and sticky overflow
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
      head     <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr   <= rd_ptr_next;
      count    <= count_next;
      rd_valid <= (count_next != '0);
      // When the FIFO goes empty the head simply keeps its last value.
      if (count_next != '0) head <= head_next;
      // A drop in the same cycle as a clear leaves the flag set.
      if (drop)           overflow <= 1'b1;
      else if (clear_ovf) overflow <= 1'b0;
    end
  end

  // Record storage write port
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; pointers and count define which
    // entries are meaningful, so stale contents are never observed.
    if (push) mem[wr_ptr] <= new_rec;
  end

endmodule

// File: tb/tb_change_monitor.sv
// Self-checking bench for change_monitor: a table of directed vectors,
// hand-written corner sequences and a randomized run against a queue model.
module tb_change_monitor;

  localparam int DW = 4;
  localparam int TW = 16;
  localparam int D  = 8;

  logic          clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (TS_W = 16)
  logic          rst_n, en, rd_ready, clear_ovf;
  logic [DW-1:0] data_in;
  logic          rd_valid, overflow;
  logic [DW-1:0] rd_data;
  logic [TW-1:0] rd_time;
  logic [3:0]    count;

  // Narrow-timestamp instance (TS_W = 4) for the wrap check
  logic          s_rst_n, s_en, s_rd_ready, s_clear_ovf;
  logic [DW-1:0] s_data_in;
  logic          s_rd_valid, s_overflow;
  logic [DW-1:0] s_rd_data;
  logic [3:0]    s_rd_time;
  logic [3:0]    s_count;

  change_monitor #(.DATA_W(DW), .TS_W(TW), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .data_in(data_in),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .rd_time(rd_time), .count(count), .overflow(overflow),
    .clear_ovf(clear_ovf)
  );

  change_monitor #(.DATA_W(DW), .TS_W(4), .DEPTH(D)) dut_small (
    .clk(clk), .rst_n(s_rst_n), .en(s_en), .data_in(s_data_in),
    .rd_valid(s_rd_valid), .rd_ready(s_rd_ready), .rd_data(s_rd_data),
    .rd_time(s_rd_time), .count(s_count), .overflow(s_overflow),
    .clear_ovf(s_clear_ovf)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model: queue of logged records ----------------
  typedef struct {
    logic [DW-1:0] d;
    int            t;
  } rec_t;

  rec_t          mq[$];
  int            m_t;
  logic [DW-1:0] m_prev;
  bit            m_primed;
  bit            m_ovf;

  task automatic model_edge(input logic r, input logic e, input logic [DW-1:0] d,
                            input logic rdy, input logic c);
    bit pop, want, drop;
    if (!r) begin
      mq.delete();
      m_t = 0; m_prev = '0; m_primed = 0; m_ovf = 0;
    end else begin
      pop  = (mq.size() > 0) && rdy;
      want = e && (!m_primed || d != m_prev);
      drop = want && (mq.size() == D) && !pop;
      if (pop) void'(mq.pop_front());
      if (want && !drop) mq.push_back('{d: d, t: m_t});
      if (drop) m_ovf = 1;
      else if (c) m_ovf = 0;
      if (e) m_prev = d;
      m_primed = e;
      m_t = (m_t + 1) % (1 << TW);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, "_count"}, count, mq.size());
    check({tag, "_valid"}, rd_valid, mq.size() > 0);
    if (mq.size() > 0) begin
      check({tag, "_data"}, rd_data, mq[0].d);
      check({tag, "_time"}, rd_time, mq[0].t);
    end
    check({tag, "_ovf"}, overflow, m_ovf);
  endtask

  // One clock of the main instance: drive, edge, advance model, settle.
  task automatic cyc(input logic r, input logic e, input logic [DW-1:0] d,
                     input logic rdy, input logic c);
    rst_n = r; en = e; data_in = d; rd_ready = rdy; clear_ovf = c;
    @(posedge clk);
    model_edge(r, e, d, rdy, c);
    #1;
  endtask

  task automatic scyc(input logic r, input logic e, input logic [DW-1:0] d,
                      input logic rdy, input logic c);
    s_rst_n = r; s_en = e; s_data_in = d; s_rd_ready = rdy; s_clear_ovf = c;
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic          r, e;
    logic [DW-1:0] d;
    logic          rdy, c;
    int            cnt;
    logic          vld;
    logic [DW-1:0] ed;
    int            et;
    logic          ovf;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic e, input logic [DW-1:0] d,
                     input logic rdy, input int cnt, input logic vld,
                     input logic [DW-1:0] ed, input int et);
    tbl.push_back('{r: r, e: e, d: d, rdy: rdy, c: 1'b0, cnt: cnt, vld: vld,
                    ed: ed, et: et, ovf: 1'b0});
  endtask

  logic [TW-1:0] last_t;

  initial begin
    rst_n = 0; en = 0; data_in = 0; rd_ready = 0; clear_ovf = 0;
    s_rst_n = 0; s_en = 0; s_data_in = 0; s_rd_ready = 0; s_clear_ovf = 0;
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    check("reset_count", count, 0);
    check("reset_valid", rd_valid, 0);
    check("reset_ovf", overflow, 0);
    check("reset_data", rd_data, 0);
    check("reset_time", rd_time, 0);

    // Held value 4 for 10 cycles: one record (0,4)
    for (int i = 0; i < 10; i++) add(1, 1, 4, 0, 1, 1, 4, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0);
    // 4 -> 5 at edge 2 -> 7 at edge 5, then drain
    add(1, 1, 4, 0, 1, 1, 4, 0);
    add(1, 1, 4, 0, 1, 1, 4, 0);
    add(1, 1, 5, 0, 2, 1, 4, 0);
    add(1, 1, 5, 0, 2, 1, 4, 0);
    add(1, 1, 5, 0, 2, 1, 4, 0);
    add(1, 1, 7, 0, 3, 1, 4, 0);
    add(1, 1, 7, 1, 2, 1, 5, 2);
    add(1, 1, 7, 1, 1, 1, 7, 5);
    add(1, 1, 7, 1, 0, 0, 0, 0);
    add(1, 1, 7, 0, 0, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].r, tbl[i].e, tbl[i].d, tbl[i].rdy, tbl[i].c);
      check($sformatf("tbl%0d_count", i), count, tbl[i].cnt);
      check($sformatf("tbl%0d_valid", i), rd_valid, tbl[i].vld);
      if (tbl[i].vld) begin
        check($sformatf("tbl%0d_data", i), rd_data, tbl[i].ed);
        check($sformatf("tbl%0d_time", i), rd_time, tbl[i].et);
      end
      check($sformatf("tbl%0d_ovf", i), overflow, tbl[i].ovf);
    end

    // Overflow: 10 changes into an 8-deep FIFO with no reader
    cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      cyc(1, 1, DW'(i + 1), 0, 0);
      check_model("ovf_fill");
    end
    check("ovf_full_count", count, 8);
    check("ovf_set", overflow, 1);
    cyc(1, 0, 0, 0, 1);
    check("ovf_cleared", overflow, 0);
    check("ovf_still_full", count, 8);
    cyc(1, 1, 15, 0, 1);
    check("ovf_set_wins", overflow, 1);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain%0d_time", i), rd_time, i);
      check($sformatf("drain%0d_data", i), rd_data, i + 1);
      cyc(1, 0, 0, 1, 0);
    end
    check("drain_empty_count", count, 0);
    check("drain_empty_valid", rd_valid, 0);
    cyc(1, 0, 0, 0, 1);
    check("drain_clear_ovf", overflow, 0);

    // Full FIFO with simultaneous push and pop every cycle
    cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(1, 1, DW'(i), 0, 0);
    check("fullpp_count0", count, 8);
    for (int i = 0; i < 10; i++) begin
      last_t = rd_time;
      cyc(1, 1, (i % 2 == 1) ? DW'(9) : DW'(10), 1, 0);
      check("fullpp_count", count, 8);
      check("fullpp_ovf", overflow, 0);
      check("fullpp_ts_incr", rd_time > last_t, 1);
      check_model("fullpp");
    end

    // Enable gap: unchanged value is logged once on re-enable
    cyc(0, 0, 0, 0, 0);
    cyc(1, 1, 3, 0, 0);
    cyc(1, 1, 3, 0, 0);
    check("engap_count_a", count, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 3, 0, 0);
      check("engap_count_off", count, 1);
    end
    cyc(1, 1, 3, 0, 0);
    check("engap_count_b", count, 2);
    cyc(1, 1, 3, 1, 0);
    check("engap_rec_data", rd_data, 3);
    check("engap_rec_time", rd_time, 5);
    check_model("engap");

    // Timestamp wrap on the 4-bit instance, then mid-operation reset
    scyc(0, 0, 0, 0, 0);
    scyc(0, 0, 0, 0, 0);
    scyc(1, 1, 0, 0, 0);
    check("wrap_valid_rise", s_rd_valid, 1);
    check("wrap_first_time", s_rd_time, 0);
    for (int i = 1; i < 16; i++) scyc(1, 1, 0, 0, 0);
    scyc(1, 1, 0, 1, 0);
    check("wrap_popped", s_count, 0);
    scyc(1, 1, 9, 0, 0);
    check("wrap_count", s_count, 1);
    check("wrap_time", s_rd_time, 1);
    check("wrap_data", s_rd_data, 9);
    scyc(1, 1, 10, 0, 0);
    scyc(1, 1, 11, 0, 0);
    check("wrap_three", s_count, 3);
    scyc(0, 1, 12, 0, 0);
    check("midrst_count", s_count, 0);
    check("midrst_valid", s_rd_valid, 0);
    check("midrst_ovf", s_overflow, 0);

    // Randomized run against the queue model
    cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 149) != 0,
          $urandom_range(0, 9) != 0,
          DW'($urandom_range(0, 3)),
          $urandom_range(0, 2) == 0,
          $urandom_range(0, 19) == 0);
      check_model($sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
